// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_pkg
// Description : Shared state encodings and result-ready constants for the
//               multi-cycle restoring divider and its EXE-stage consumer.
// Revision    : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Ready flag values seen by EXE
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage : div_unit_pkg
`default_nettype wire

// File: rtl/div_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : div_sign_fix
// Description : Combinational conditional two's-complement negate. Used for
//               operand magnitudes and for the quotient/remainder sign fix.
// Revision    : 1.0 - initial release
// ============================================================================
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] data_o
);

  // Negate when requested, otherwise pass through unchanged
  always_comb begin
    data_o = data_i;
    if (neg_i) begin
      data_o = '0 - data_i;
    end
  end

endmodule : div_sign_fix
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle radix-2 restoring divider (DIV / DIVU) for the
//               execute stage. Produces {remainder, quotient}.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               signed_q, signed_d;
  logic               neg1_q, neg1_d;     // dividend was negative
  logic               neg2_q, neg2_d;     // divisor was negative
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               w_op1_neg, w_op2_neg;
  logic [WIDTH-1:0]   w_op1_mag, w_op2_mag;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_trial;
  logic               w_fits;

  assign w_op1_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign w_op2_neg = signed_div_i & opdata2_i[WIDTH-1];

  div_sign_fix #(.WIDTH(WIDTH)) u_mag1 (
    .data_i (opdata1_i),
    .neg_i  (w_op1_neg),
    .data_o (w_op1_mag)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_mag2 (
    .data_i (opdata2_i),
    .neg_i  (w_op2_neg),
    .data_o (w_op2_mag)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_quo_fix (
    .data_i (quo_q),
    .neg_i  (signed_q & (neg1_q ^ neg2_q)),
    .data_o (w_quo_fix)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_rem_fix (
    .data_i (rem_q),
    .neg_i  (signed_q & neg1_q),
    .data_o (w_rem_fix)
  );

  // One restoring step: shift in the next dividend bit and trial-subtract.
  // The shifted value keeps an extra MSB so the compare is exact; when it
  // fits, the difference is below the divisor and so fits in WIDTH bits.
  always_comb begin
    w_shift = {rem_q, quo_q[WIDTH-1]};
    w_fits  = (w_shift >= {1'b0, divisor_q});
    w_trial = w_shift[WIDTH-1:0] - divisor_q;
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    signed_d  = signed_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      DIV_IDLE: begin
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d   = DIV_ON;
            signed_d  = signed_div_i;
            neg1_d    = w_op1_neg;
            neg2_d    = w_op2_neg;
            divisor_d = w_op2_mag;
            quo_d     = w_op1_mag;
            rem_d     = '0;
            cnt_d     = '0;
          end
        end
      end

      DIV_BY_ZERO: begin
        // Architecturally undefined; pinned to zero
        state_d  = DIV_END;
        result_d = '0;
        ready_d  = DIV_RESULT_READY;
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_IDLE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d  = DIV_END;
          result_d = {w_rem_fix, w_quo_fix};
          ready_d  = DIV_RESULT_READY;
        end else begin
          rem_d = w_fits ? w_trial : w_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], w_fits};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DIV_END: begin
        if (!start_i || annul_i) begin
          state_d  = DIV_IDLE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      signed_q  <= 1'b0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      signed_q  <= signed_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q != DIV_IDLE);

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit: directed vector table,
//               annul / async-reset sequences and random operations against
//               a plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

  localparam int WIDTH = 32;

  logic               clk;
  logic               resetn;
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               busy_o;

  int total = 0;
  int bad   = 0;

  div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: 64-bit integer division truncates toward zero and the
  // remainder takes the dividend's sign, exactly the DIV/DIVU rules.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  task automatic wait_ready(output int k);
    k = 0;
    while (!ready_o && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  // Launch one operation, check latency and result, hold, then release
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
    int k;
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    wait_ready(k);
    check({tag, "_latency"}, 64'(k), (b == 32'd0) ? 64'd2 : 64'(WIDTH + 2));
    check({tag, "_result"}, result_o, exp);
    check({tag, "_busy"}, 64'(busy_o), 64'd1);
    @(negedge clk);
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    repeat (2) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
      check({tag, "_hold_result"}, result_o, exp);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
    check({tag, "_drop_result"}, result_o, 64'd0);
    check({tag, "_drop_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int k;
    logic        rs;
    logic [31:0] ra, rb;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001};
    vecs[3] = '{1'b0, 32'd5,          32'd0,          32'h00000000, 32'h00000000};
    vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000};
    vecs[5] = '{1'b0, 32'd1000,       32'd3,          32'h0000014D, 32'h00000001};
    vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'h00000000};
    vecs[7] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE};

    resetn       = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, {vecs[i].r, vecs[i].q}, $sformatf("vec%0d", i));
    end

    // Annul at edge 10, then a clean rerun of the same division
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("annul_busy_before", 64'(busy_o), 64'd1);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul_busy", 64'(busy_o), 64'd0);
    check("annul_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("annul_stay_ready", 64'(ready_o), 64'd0);
    end
    run_op(1'b0, 32'd1000, 32'd3, {32'd1, 32'h14D}, "annul_rerun");

    // Asynchronous reset in the middle of an iteration
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'hFFFFFFFF;
    opdata2_i    = 32'd1;
    start_i      = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("areset_on_busy_before", 64'(busy_o), 64'd1);
    resetn = 1'b0;
    #1;
    check("areset_on_busy", 64'(busy_o), 64'd0);
    check("areset_on_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    resetn  = 1'b1;

    // Asynchronous reset while a result is being held
    @(negedge clk);
    opdata1_i = 32'd7;
    opdata2_i = 32'd2;
    start_i   = 1'b1;
    wait_ready(k);
    check("areset_end_result_before", result_o, {32'd1, 32'd3});
    #1;
    resetn = 1'b0;
    #1;
    check("areset_end_result", result_o, 64'd0);
    check("areset_end_ready", 64'(ready_o), 64'd0);
    check("areset_end_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    resetn  = 1'b1;
    run_op(1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, "areset_rerun");

    // Random operations against the reference model
    for (int i = 0; i < 30; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = (($urandom_range(0, 3)) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      run_op(rs, ra, rb, model(rs, ra, rb), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_div_unit
`default_nettype wire
